// File: rtl/rx_medida_7o1_if.sv
// Receiver-side bundle for the 7O1 measurement link and its outputs.
// Signals: entrada_serial (raw UART line), medida (BCD), pronto/erro pulses, debug taps.
// master = receiver (reads the line, drives results); slave = host/display side.
interface rx_medida_7o1_if;
    logic        entrada_serial;
    logic [11:0] medida;
    logic        pronto;
    logic        erro;
    logic [1:0]  db_indice;
    logic [3:0]  db_estado;

    modport master (
        input  entrada_serial,
        output medida,
        output pronto,
        output erro,
        output db_indice,
        output db_estado
    );

    modport slave (
        output entrada_serial,
        input  medida,
        input  pronto,
        input  erro,
        input  db_indice,
        input  db_estado
    );
endinterface

// File: rtl/rx_medida_7o1.sv
// Receives 7O1 UART characters and parses "DDD#" frames into a 12-bit BCD measurement.
// Latency: pronto/erro pulse one cycle after the stop-bit sample (2-flop synchronizer ahead).
// No backpressure: results are one-cycle pulses; medida holds the last accepted frame.
// Ports: clock, reset (async active-low), bus (master modport: entrada_serial in;
//        medida, pronto, erro, db_indice, db_estado out).
module rx_medida_7o1 #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic              clock,
    input  logic              reset,
    rx_medida_7o1_if.master   bus
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [3:0] {
        OCIOSO   = 4'd0,
        INICIO   = 4'd1,
        DADOS    = 4'd2,
        PARIDADE = 4'd3,
        PARADA   = 4'd4
    } estado_t;

    // ------------------------------------------------------------------
    // Input synchronizer; both flops reset to the idle (high) line level.
    // ------------------------------------------------------------------
    logic s_meta;
    logic s_rx;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s_meta <= 1'b1;
            s_rx   <= 1'b1;
        end else begin
            s_meta <= bus.entrada_serial;
            s_rx   <= s_meta;
        end
    end

    // ------------------------------------------------------------------
    // Bit FSM
    // ------------------------------------------------------------------
    estado_t         estado;
    logic [CW-1:0]   cnt;
    logic [2:0]      nbit;
    logic [6:0]      caractere;
    logic            par_ok;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado    <= OCIOSO;
            cnt       <= '0;
            nbit      <= '0;
            caractere <= '0;
            par_ok    <= 1'b0;
        end else begin
            unique case (estado)
                OCIOSO: begin
                    if (!s_rx) begin
                        cnt    <= '0;
                        estado <= INICIO;
                    end
                end
                INICIO: begin
                    // Mid-start resample filters short low glitches.
                    if (cnt == HALF_M1) begin
                        cnt    <= '0;
                        nbit   <= '0;
                        estado <= s_rx ? OCIOSO : DADOS;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DADOS: begin
                    if (cnt == FULL_M1) begin
                        cnt       <= '0;
                        caractere <= {s_rx, caractere[6:1]};
                        if (nbit == 3'd6) begin
                            estado <= PARIDADE;
                        end else begin
                            nbit <= nbit + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PARIDADE: begin
                    if (cnt == FULL_M1) begin
                        cnt    <= '0;
                        par_ok <= ^{caractere, s_rx};
                        estado <= PARADA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PARADA: begin
                    // Leave at the stop midpoint so a back-to-back start edge
                    // half a bit later is seen from OCIOSO.
                    if (cnt == FULL_M1) begin
                        cnt    <= '0;
                        estado <= OCIOSO;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    estado <= OCIOSO;
                end
            endcase
        end
    end

    // Character strobe coincides with the stop-bit sample; caractere is
    // complete at that point and the frame FSM registers its reaction.
    logic char_rx;
    logic char_ok;

    assign char_rx = (estado == PARADA) && (cnt == FULL_M1);
    assign char_ok = par_ok & s_rx;

    logic e_digito;
    logic e_cerquilha;

    assign e_digito    = (caractere[6:4] == 3'b011) && (caractere[3:0] <= 4'd9);
    assign e_cerquilha = (caractere == 7'h23);

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    logic [1:0]  indice;
    logic        descarta;
    logic [3:0]  dig_c;     // hundreds
    logic [3:0]  dig_d;     // tens
    logic [3:0]  dig_u;     // units
    logic [11:0] medida_r;
    logic        pronto_r;
    logic        erro_r;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            indice   <= '0;
            descarta <= 1'b0;
            dig_c    <= '0;
            dig_d    <= '0;
            dig_u    <= '0;
            medida_r <= '0;
            pronto_r <= 1'b0;
            erro_r   <= 1'b0;
        end else begin
            pronto_r <= 1'b0;
            erro_r   <= 1'b0;
            if (char_rx) begin
                if (descarta) begin
                    // Silent resync: only a well-formed '#' ends discarding.
                    if (char_ok && e_cerquilha) begin
                        descarta <= 1'b0;
                        indice   <= '0;
                    end
                end else if (!char_ok) begin
                    erro_r   <= 1'b1;
                    descarta <= 1'b1;
                    indice   <= '0;
                end else if (indice != 2'd3) begin
                    if (e_digito) begin
                        case (indice)
                            2'd0:    dig_c <= caractere[3:0];
                            2'd1:    dig_d <= caractere[3:0];
                            default: dig_u <= caractere[3:0];
                        endcase
                        indice <= indice + 1'b1;
                    end else begin
                        // A valid '#' arriving early is itself a frame
                        // boundary, so only other characters force discard.
                        erro_r   <= 1'b1;
                        descarta <= !e_cerquilha;
                        indice   <= '0;
                    end
                end else begin
                    if (e_cerquilha) begin
                        medida_r <= {dig_c, dig_d, dig_u};
                        pronto_r <= 1'b1;
                    end else begin
                        erro_r   <= 1'b1;
                        descarta <= 1'b1;
                    end
                    indice <= '0;
                end
            end
        end
    end

    assign bus.medida    = medida_r;
    assign bus.pronto    = pronto_r;
    assign bus.erro      = erro_r;
    assign bus.db_indice = indice;
    assign bus.db_estado = estado;

endmodule

// File: tb/tb_rx_medida_7o1.sv
module tb_rx_medida_7o1;

    localparam int CPB = 16;

    logic clock = 1'b0;
    logic reset = 1'b0;

    always #5 clock = ~clock;

    rx_medida_7o1_if bus ();

    rx_medida_7o1 #(.CLKS_PER_BIT(CPB)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int          kind;   // 1 = pronto, 2 = erro
        logic [11:0] med;
    } ev_t;

    typedef struct {
        logic [31:0] txt;
        int          len;
        int          bad_par;    // char index with inverted parity, -1 none
        int          bad_stop;   // char index with stop bit 0, -1 none
        int          bit_ns;
        int          gap_ns;
        logic [11:0] exp_med;    // medida expected once the frame is done
        bit          exp_pronto; // 1: frame accepted, 0: one erro pulse
    } vec_t;

    ev_t  exp_q[$];
    vec_t vecs[13];
    int   ncmp  = 0;
    int   nfail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard side: every pulse must match the oldest expected event.
    always @(negedge clock) begin
        if (reset && (bus.pronto || bus.erro)) begin
            ev_t e;
            chk("pronto_erro_exclusive", {31'd0, bus.pronto & bus.erro}, 32'd0);
            if (exp_q.size() == 0) begin
                ncmp++;
                nfail++;
                $display("FAIL unexpected_pulse: got pronto=%0b erro=%0b, expected none", bus.pronto, bus.erro);
            end else begin
                e = exp_q.pop_front();
                chk("pulse_kind", bus.pronto ? 32'd1 : 32'd2, e.kind);
                if (e.kind == 1)
                    chk("medida_at_pronto", {20'd0, bus.medida}, {20'd0, e.med});
            end
        end
    end

    task automatic send_char(input logic [6:0] c, input bit bad_par, input bit bad_stop, input int bit_ns);
        logic p;
        p = ~(^c);
        if (bad_par) p = ~p;
        bus.entrada_serial = 1'b0;
        #(bit_ns);
        for (int b = 0; b < 7; b++) begin
            bus.entrada_serial = c[b];
            #(bit_ns);
        end
        bus.entrada_serial = p;
        #(bit_ns);
        bus.entrada_serial = ~bad_stop;
        #(bit_ns);
        bus.entrada_serial = 1'b1;
    endtask

    task automatic settle_align(input int cycles);
        repeat (cycles) @(negedge clock);
        #3;
    endtask

    task automatic wait_drain(input string name);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 4000) begin
            @(negedge clock);
            t++;
        end
        chk(name, exp_q.size(), 32'd0);
        settle_align(4);
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        ev_t  e;
        logic [31:0] t;
        v = vecs[i];
        t = v.txt;
        e.kind = v.exp_pronto ? 1 : 2;
        e.med  = v.exp_med;
        exp_q.push_back(e);
        for (int j = 0; j < v.len; j++)
            send_char(t[8*(v.len-1-j) +: 7], j == v.bad_par, j == v.bad_stop, v.bit_ns);
        if (v.gap_ns > 0) begin
            #(v.gap_ns);
            wait_drain($sformatf("drain_vec%0d", i));
            chk($sformatf("medida_vec%0d", i), {20'd0, bus.medida}, {20'd0, v.exp_med});
            chk($sformatf("indice_vec%0d", i), {30'd0, bus.db_indice}, 32'd0);
            chk($sformatf("estado_vec%0d", i), {28'd0, bus.db_estado}, 32'd0);
        end
    endtask

    initial begin
        ev_t e;
        vecs[0]  = '{"123#", 4, -1, -1, 160, 400, 12'h123, 1'b1};
        vecs[1]  = '{"456#", 4,  1, -1, 160, 400, 12'h123, 1'b0};
        vecs[2]  = '{"789#", 4, -1, -1, 160, 400, 12'h789, 1'b1};
        vecs[3]  = '{"12#",  3, -1, -1, 160, 400, 12'h789, 1'b0};
        vecs[4]  = '{"050#", 4, -1, -1, 160, 400, 12'h050, 1'b1};
        vecs[5]  = '{"1A3#", 4, -1, -1, 160, 400, 12'h050, 1'b0};
        vecs[6]  = '{"999#", 4, -1, -1, 160, 400, 12'h999, 1'b1};
        vecs[7]  = '{"321#", 4, -1, -1, 160, 400, 12'h321, 1'b1};
        vecs[8]  = '{"210#", 4, -1, -1, 160, 400, 12'h210, 1'b1};
        vecs[9]  = '{"111#", 4, -1, -1, 160,   0, 12'h111, 1'b1};
        vecs[10] = '{"222#", 4, -1, -1, 160, 400, 12'h222, 1'b1};
        vecs[11] = '{"111#", 4, -1, -1, 155,   0, 12'h111, 1'b1};
        vecs[12] = '{"222#", 4, -1, -1, 155, 400, 12'h222, 1'b1};

        bus.entrada_serial = 1'b1;
        reset = 1'b0;
        repeat (3) @(negedge clock);
        chk("reset_medida", {20'd0, bus.medida}, 32'd0);
        chk("reset_pronto", {31'd0, bus.pronto}, 32'd0);
        chk("reset_erro",   {31'd0, bus.erro},   32'd0);
        chk("reset_indice", {30'd0, bus.db_indice}, 32'd0);
        chk("reset_estado", {28'd0, bus.db_estado}, 32'd0);
        reset = 1'b1;
        settle_align(4);

        for (int i = 0; i <= 6; i++) run_vec(i);

        // Short low glitch: start detected, rejected at the mid-start resample.
        bus.entrada_serial = 1'b0;
        #40;
        bus.entrada_serial = 1'b1;
        #20;
        chk("glitch_in_inicio", {28'd0, bus.db_estado}, 32'd1);
        #300;
        chk("glitch_back_ocioso", {28'd0, bus.db_estado}, 32'd0);
        chk("glitch_medida_kept", {20'd0, bus.medida}, 32'h999);
        settle_align(1);
        run_vec(7);

        // Stop bit low on a lone character.
        e.kind = 2;
        e.med  = 12'h321;
        exp_q.push_back(e);
        send_char(7'h35, 1'b0, 1'b1, 160);
        #400;
        wait_drain("drain_bad_stop");

        // Reset in the middle of the data bits of '6' (0x36).
        bus.entrada_serial = 1'b0;
        #160;
        bus.entrada_serial = 1'b0;
        #160;
        bus.entrada_serial = 1'b1;
        #160;
        bus.entrada_serial = 1'b1;
        #80;
        chk("mid_char_estado", {28'd0, bus.db_estado}, 32'd2);
        reset = 1'b0;
        #1;
        chk("midreset_medida", {20'd0, bus.medida}, 32'd0);
        chk("midreset_pronto", {31'd0, bus.pronto}, 32'd0);
        chk("midreset_erro",   {31'd0, bus.erro},   32'd0);
        chk("midreset_indice", {30'd0, bus.db_indice}, 32'd0);
        chk("midreset_estado", {28'd0, bus.db_estado}, 32'd0);
        bus.entrada_serial = 1'b1;
        #50;
        reset = 1'b1;
        settle_align(20);

        for (int i = 8; i <= 12; i++) run_vec(i);

        settle_align(50);
        chk("queue_empty_end", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/rx_medida_7o1.md
# rx_medida_7O1

Serial receiver for distance-measurement frames, the receiving end of the sonar's `saida_serial` link. It samples an asynchronous 7O1 UART line: 7 data bits, odd parity, 1 stop bit. It parses frames of three ASCII decimal digits followed by `#` into a 12-bit BCD measurement. It sits on the host/display board next to the `hexa7seg` decoders and drives them with the same `medida[11:0]` layout the sensor produces.

## Interface

**Parameters**
- `CLKS_PER_BIT`, default 434: clock cycles per bit (50 MHz / 115200 baud). Must be ≥ 8.

**Ports**
- `clock`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `entrada_serial`  in  1  UART line. Idle high. Asynchronous to `clock`.
- `medida`  out  12  last valid frame as BCD: [11:8] hundreds, [7:4] tens, [3:0] units.
- `pronto`  out  1  one-cycle pulse; `medida` updated this cycle.
- `erro`  out  1  one-cycle pulse; a frame was rejected.
- `db_indice`  out  2  current character position in the frame (0..3).
- `db_estado`  out  4  bit-FSM state, for a `hexa7seg` debug display.

## Operation

**Reset** (while `reset` is low): `medida` = 0, `pronto` = 0, `erro` = 0, `db_indice` = 0, bit FSM in OCIOSO. Both synchronizer flops reset to 1 (line idle).

**Input synchronizer**
- `entrada_serial` passes through a 2-flop synchronizer; all sampling uses its output `s_rx`.

**Bit FSM** (`db_estado` encoding in brackets)
- OCIOSO [0]: wait for `s_rx` = 0, then clear the bit counter and go to INICIO.
- INICIO [1]: at count `CLKS_PER_BIT/2 − 1`, resample the line.
  - 1 → false start: return to OCIOSO with no effect on outputs.
  - 0 → go to DADOS.
- DADOS [2]: sample every `CLKS_PER_BIT` cycles. 7 bits, LSB first, shifted into `caractere[6:0]`.
- PARIDADE [3]: sample the parity bit. `par_ok` = 1 when the XOR of the 7 data bits and the parity bit is 1 (odd parity).
- PARADA [4]: sample the stop bit.
  - Character valid = `par_ok` and stop = 1.
  - Issue a one-cycle `char_rx` strobe with a `char_ok` flag.
  - Return to OCIOSO in the same cycle, so a start bit that begins right after the stop midpoint is caught.

**Frame FSM** (`db_indice` = character position)
- At positions 0–2, a valid character in 0x30–0x39 stores `caractere[3:0]` into the shadow digit for that position and advances the position.
- At position 3, a valid `#` (0x23) does the following, then returns to position 0:
  - `medida` ← {d2, d1, d0};
  - `pronto` pulses.

**Rejection** (any of these pulses `erro` and leaves `medida` unchanged)
- Parity or stop failure.
- A non-digit at positions 0–2.
- A non-`#` at position 3.

**Recovery after rejection**
- If the offending character was a valid `#`: go to position 0, so the `#` resynchronizes.
- Otherwise: go to DESCARTA. It ignores every character until a valid `#`, then goes to position 0 with no further pulse.
- While in DESCARTA, `db_indice` reads 0.

**Other rules**
- `pronto` and `erro` are never high in the same cycle.
- Reset asserted mid-character or mid-frame discards all partial state immediately.

## Timing
- Sample points, measured from the first cycle `s_rx` is low:
  - start bit: cycle `CLKS_PER_BIT/2`;
  - bit k (k = 1..9: data, parity, stop): cycle `CLKS_PER_BIT/2 + k·CLKS_PER_BIT`.
- Synchronizer adds 2 cycles between `entrada_serial` and `s_rx`.
- `pronto`/`erro` rise 1 cycle after the stop-bit sample. That is ≤ 9.5·`CLKS_PER_BIT` + 4 cycles after the falling edge of the final character's start bit.
- `medida` changes in the same cycle `pronto` rises and holds until the next accepted frame.
- Tolerance: a frame is received correctly with ±3% baud mismatch and with zero idle time between characters or frames.
- Low pulses shorter than `CLKS_PER_BIT/2 − 2` cycles are rejected as false starts.

## Test plan
Use `CLKS_PER_BIT` = 16 for simulation; the transmit model computes parity itself.

1. Send `123#` after reset → exactly one `pronto` pulse, `medida` = 0x123, `erro` never high, `db_estado` back to 0.
2. Send `456#` with the parity bit of `5` inverted → one `erro` pulse, no `pronto`, `medida` stays 0x123. Then send `789#` → `medida` = 0x789.
3. Send `12#` → `erro` at the `#`, `db_indice` = 0. Then send `050#` → `medida` = 0x050. Also send `1A3#` → `erro`, DESCARTA until the `#`. A following `999#` → 0x999.
4. Drive a 4-cycle low glitch on the idle line → no strobe, FSM returns to OCIOSO. Then send `321#` → 0x321.
5. Send a character with stop bit = 0 → `erro`. Then assert `reset` in the middle of the data bits of `6` in `654#` → all outputs 0 immediately. After release, `210#` → 0x210.
6. Send `111#222#` back-to-back with no idle gap, once at nominal baud and once at +3% baud → two `pronto` pulses (0x111, then 0x222), no `erro`.
